phase_sequencer: RTL and testbench

//   Parametrised intersection phase sequencer for NUM_PHASES traffic/pedestrian phases.

---
 rtl/phase_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_phase_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Round-robin intersection phase sequencer. Grants one of NUM_PHASES phases at
//   a time (one-hot), waits for that phase's done, clears its timer, inserts an
//   all-red clearance interval and then grants the next phase with demand.
//   Service mode blanks every phase and drives a flashing beacon.
//
//   Optional feature macro: PHASE_WATCHDOG_EN
//     defined   -> a watchdog counts green cycles; WD_CYCLES without done moves
//                  the sequencer to a sticky FAULT state (all red, fault_o=1).
//     undefined -> no watchdog and no FAULT state; fault_o is tied low.
//
// Ports
//   clk_i           clock
//   reset_n         asynchronous active-low reset
//   enable_i        run request, evaluated at the end of clearance / in IDLE
//   service_i       service mode request (level), highest priority
//   demand_i        per-phase demand; phases without demand are skipped
//   done_i          per-phase done from the timer blocks
//   phase_en_o      one-hot grant of the active phase
//   clear_o         one-cycle clear pulse to the timer of the finished phase
//   active_phase_o  index of the last granted phase
//   all_red_o       high during clearance, IDLE and FAULT
//   service_o       high while in service mode
//   flash_o         service beacon, low outside service mode
//   fault_o         sticky watchdog fault flag
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int NUM_PHASES   = 5,
    parameter int CLEAR_CYCLES = 4,
    parameter int FLASH_HALF   = 8,
    parameter int WD_CYCLES    = 1024,
    parameter int PW           = $clog2(NUM_PHASES)
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  service_i,
    input  logic [NUM_PHASES-1:0] demand_i,
    input  logic [NUM_PHASES-1:0] done_i,
    output logic [NUM_PHASES-1:0] phase_en_o,
    output logic [NUM_PHASES-1:0] clear_o,
    output logic [PW-1:0]         active_phase_o,
    output logic                  all_red_o,
    output logic                  service_o,
    output logic                  flash_o,
    output logic                  fault_o
);

    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [PW-1:0]         LAST_IDX   = PW'(NUM_PHASES - 1);
    localparam logic [CW-1:0]         CLR_LAST   = CW'(CLEAR_CYCLES - 1);
    localparam logic [FW-1:0]         FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [NUM_PHASES-1:0] NO_PHASE   = {NUM_PHASES{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GREEN   = 3'd1,
        ST_CLEAR   = 3'd2,
`ifdef PHASE_WATCHDOG_EN
        ST_SERVICE = 3'd3,
        ST_FAULT   = 3'd4
`else
        ST_SERVICE = 3'd3
`endif
    } state_t;

    state_t                  state_q;
    logic [NUM_PHASES-1:0]   phase_en_q;
    logic [NUM_PHASES-1:0]   clear_q;
    logic [PW-1:0]           active_phase_q;
    logic                    all_red_q;
    logic                    service_q;
    logic                    flash_q;
    logic [CW-1:0]           clr_cnt_q;
    logic [FW-1:0]           flash_cnt_q;

    logic                    search_hit_s;
    logic [PW-1:0]           search_idx_s;
    logic                    done_hit_s;

`ifdef PHASE_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);
    logic [WW-1:0]           wd_cnt_q;
    logic                    fault_q;
`else
    logic [31:0]             wd_cfg_unused_s;
    assign wd_cfg_unused_s = 32'(WD_CYCLES);
`endif

    // Round-robin search: offsets 1..NUM_PHASES from base, so base itself is
    // checked last. Walking the offsets downward lets the nearest hit win.
    function automatic logic [PW:0] next_phase(input logic [PW-1:0]         base,
                                               input logic [NUM_PHASES-1:0] dem);
        logic [PW:0] res;
        int          idx;
        res = {(PW + 1){1'b0}};
        for (int i = NUM_PHASES; i >= 1; i--) begin
            idx = (int'(base) + i) % NUM_PHASES;
            if (dem[idx]) begin
                res = {1'b1, PW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_PHASES-1:0] onehot(input logic [PW-1:0] idx);
        return {{(NUM_PHASES - 1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next-phase search and done qualification against the current grant.
    always_comb begin
        {search_hit_s, search_idx_s} = next_phase(active_phase_q, demand_i);
        done_hit_s                   = |(done_i & phase_en_q);
    end

    // Sequencer FSM with registered outputs; service beats done beats enable.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            phase_en_q     <= NO_PHASE;
            clear_q        <= NO_PHASE;
            active_phase_q <= LAST_IDX;
            all_red_q      <= 1'b1;
            service_q      <= 1'b0;
            flash_q        <= 1'b0;
            clr_cnt_q      <= {CW{1'b0}};
            flash_cnt_q    <= {FW{1'b0}};
`ifdef PHASE_WATCHDOG_EN
            wd_cnt_q       <= {WW{1'b0}};
            fault_q        <= 1'b0;
`endif
        end else begin
            clear_q <= NO_PHASE;
            if (service_i) begin
                if (state_q != ST_SERVICE) begin
                    // Pre-emption: the green timer is not cleared here.
                    state_q     <= ST_SERVICE;
                    phase_en_q  <= NO_PHASE;
                    all_red_q   <= 1'b0;
                    service_q   <= 1'b1;
                    flash_q     <= 1'b1;
                    flash_cnt_q <= {FW{1'b0}};
`ifdef PHASE_WATCHDOG_EN
                    fault_q     <= 1'b0;
`endif
                end else if (flash_cnt_q == FLASH_LAST) begin
                    flash_q     <= ~flash_q;
                    flash_cnt_q <= {FW{1'b0}};
                end else begin
                    flash_cnt_q <= flash_cnt_q + {{(FW - 1){1'b0}}, 1'b1};
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable_i) begin
                            // Pointer at the last index so the first grant is phase 0.
                            state_q        <= ST_CLEAR;
                            active_phase_q <= LAST_IDX;
                            clr_cnt_q      <= {CW{1'b0}};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_GREEN: begin
                        if (done_hit_s) begin
                            state_q    <= ST_CLEAR;
                            clear_q    <= phase_en_q;
                            phase_en_q <= NO_PHASE;
                            all_red_q  <= 1'b1;
                            clr_cnt_q  <= {CW{1'b0}};
`ifdef PHASE_WATCHDOG_EN
                        end else if (wd_cnt_q == WD_LAST) begin
                            state_q    <= ST_FAULT;
                            phase_en_q <= NO_PHASE;
                            all_red_q  <= 1'b1;
                            fault_q    <= 1'b1;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + {{(WW - 1){1'b0}}, 1'b1};
                        end
`else
                        end else begin
                            state_q <= ST_GREEN;
                        end
`endif
                    end
                    ST_CLEAR: begin
                        // The counter saturates on its last value while no demand is found,
                        // so the search repeats every cycle without a new interval.
                        if (clr_cnt_q != CLR_LAST) begin
                            clr_cnt_q <= clr_cnt_q + {{(CW - 1){1'b0}}, 1'b1};
                        end else if (!enable_i) begin
                            state_q <= ST_IDLE;
                        end else if (search_hit_s) begin
                            state_q        <= ST_GREEN;
                            phase_en_q     <= onehot(search_idx_s);
                            active_phase_q <= search_idx_s;
                            all_red_q      <= 1'b0;
`ifdef PHASE_WATCHDOG_EN
                            wd_cnt_q       <= {WW{1'b0}};
`endif
                        end else begin
                            state_q <= ST_CLEAR;
                        end
                    end
                    ST_SERVICE: begin
                        state_q        <= ST_CLEAR;
                        active_phase_q <= LAST_IDX;
                        clr_cnt_q      <= {CW{1'b0}};
                        all_red_q      <= 1'b1;
                        service_q      <= 1'b0;
                        flash_q        <= 1'b0;
                        flash_cnt_q    <= {FW{1'b0}};
                    end
`ifdef PHASE_WATCHDOG_EN
                    ST_FAULT: begin
                        state_q <= ST_FAULT;
                    end
`endif
                    default: begin
                        state_q    <= ST_IDLE;
                        phase_en_q <= NO_PHASE;
                        all_red_q  <= 1'b1;
                        service_q  <= 1'b0;
                        flash_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign phase_en_o     = phase_en_q;
    assign clear_o        = clear_q;
    assign active_phase_o = active_phase_q;
    assign all_red_o      = all_red_q;
    assign service_o      = service_q;
    assign flash_o        = flash_q;
`ifdef PHASE_WATCHDOG_EN
    assign fault_o        = fault_q;
`else
    assign fault_o        = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    localparam int N = 5;
    localparam int C = 4;
    localparam int F = 8;

    localparam int M_IDLE  = 0;
    localparam int M_GREEN = 1;
    localparam int M_CLEAR = 2;
    localparam int M_SERV  = 3;

    logic         clk_i = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable_i = 1'b0;
    logic         service_i = 1'b0;
    logic [N-1:0] demand_i = 5'b00000;
    logic [N-1:0] done_i = 5'b00000;
    logic [N-1:0] phase_en_o;
    logic [N-1:0] clear_o;
    logic [2:0]   active_phase_o;
    logic         all_red_o;
    logic         service_o;
    logic         flash_o;
    logic         fault_o;

    phase_sequencer #(.NUM_PHASES(N), .CLEAR_CYCLES(C), .FLASH_HALF(F), .WD_CYCLES(16)) dut (
        .clk_i(clk_i), .reset_n(reset_n), .enable_i(enable_i), .service_i(service_i),
        .demand_i(demand_i), .done_i(done_i), .phase_en_o(phase_en_o), .clear_o(clear_o),
        .active_phase_o(active_phase_o), .all_red_o(all_red_o), .service_o(service_o),
        .flash_o(flash_o), .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // reference model: what the intersection is doing, in plain terms
    int m_mode;
    int m_last;     // last granted phase / search base
    int m_clr_el;   // clearance cycles shown so far
    int m_serv_n;   // cycles spent in service mode
    int m_pulse;    // phase whose timer is cleared this cycle, -1 none

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_mode = M_IDLE; m_last = N - 1; m_clr_el = 0; m_serv_n = 0; m_pulse = -1;
    endfunction

    function automatic void m_step(input logic en, input logic svc,
                                   input logic [N-1:0] dem, input logic [N-1:0] dn);
        m_pulse = -1;
        if (svc) begin
            if (m_mode != M_SERV) begin m_mode = M_SERV; m_serv_n = 0; end
            m_serv_n++;
        end else if (m_mode == M_SERV) begin
            m_mode = M_CLEAR; m_clr_el = 1; m_last = N - 1;
        end else if (m_mode == M_IDLE) begin
            if (en) begin m_mode = M_CLEAR; m_clr_el = 1; m_last = N - 1; end
        end else if (m_mode == M_GREEN) begin
            if (dn[m_last]) begin m_pulse = m_last; m_mode = M_CLEAR; m_clr_el = 1; end
        end else begin
            if (m_clr_el < C) m_clr_el++;
            else if (!en) m_mode = M_IDLE;
            else begin
                for (int i = 1; i <= N; i++) begin
                    int j;
                    j = (m_last + i) % N;
                    if (dem[j]) begin m_mode = M_GREEN; m_last = j; break; end
                end
            end
        end
    endfunction

    task automatic model_cmp();
        logic [N-1:0] e_pe, e_clr;
        logic         e_fl;
        e_pe  = (m_mode == M_GREEN) ? 5'(1 << m_last) : 5'b00000;
        e_clr = (m_pulse >= 0) ? 5'(1 << m_pulse) : 5'b00000;
        e_fl  = (m_mode == M_SERV) && ((((m_serv_n - 1) / F) % 2) == 0);
        chk("m_phase_en", 32'(phase_en_o), 32'(e_pe));
        chk("m_clear", 32'(clear_o), 32'(e_clr));
        chk("m_active", 32'(active_phase_o), 32'(m_last));
        chk("m_all_red", 32'(all_red_o), 32'(m_mode == M_IDLE || m_mode == M_CLEAR));
        chk("m_service", 32'(service_o), 32'(m_mode == M_SERV));
        chk("m_flash", 32'(flash_o), 32'(e_fl));
        chk("m_fault", 32'(fault_o), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        m_step(enable_i, service_i, demand_i, done_i);
        #1;
        model_cmp();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase_en"}, 32'(phase_en_o), 32'd0);
        chk({tag, "_clear"}, 32'(clear_o), 32'd0);
        chk({tag, "_active"}, 32'(active_phase_o), 32'd4);
        chk({tag, "_all_red"}, 32'(all_red_o), 32'd1);
        chk({tag, "_service"}, 32'(service_o), 32'd0);
        chk({tag, "_flash"}, 32'(flash_o), 32'd0);
        chk({tag, "_fault"}, 32'(fault_o), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable_i = 1'b0; service_i = 1'b0; demand_i = 5'b00000; done_i = 5'b00000;
        m_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk_reset_vals("reset");
        reset_n = 1'b1;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic en; logic svc; logic [N-1:0] dem; logic [N-1:0] dn;
        logic [N-1:0] pe; logic [N-1:0] clr; logic [2:0] ap; logic ar; logic sv; logic fl;
    } vec_t;

    vec_t vt[17];
    int   exp_g[$];

    // grant-order scenario: done pulsed 3 cycles after each grant
    task automatic run_grants(input logic [N-1:0] dem, input string tag);
        int           grants[$];
        int           red_run, age;
        bit           granted;
        logic [N-1:0] seen;
        red_run = 0; age = 0; granted = 1'b0; seen = 5'b00000;
        enable_i = 1'b1; demand_i = dem;
        for (int cyc = 0; cyc < 300 && grants.size() < exp_g.size(); cyc++) begin
            cycle();
            done_i = 5'b00000;
            seen = seen | phase_en_o;
            if (phase_en_o != 5'b00000) begin
                if (!granted) begin
                    grants.push_back(idx_of(phase_en_o));
                    if (grants.size() > 1) chk({tag, "_red_gap"}, 32'(red_run), 32'(C));
                    granted = 1'b1; age = 0;
                end
                age++;
                if (age == 3) done_i = phase_en_o;
                red_run = 0;
            end else begin
                granted = 1'b0;
                if (all_red_o) red_run++;
            end
        end
        chk({tag, "_grant_count"}, 32'(grants.size()), 32'(exp_g.size()));
        for (int i = 0; i < grants.size() && i < exp_g.size(); i++)
            chk({tag, "_grant_order"}, 32'(grants[i]), 32'(exp_g[i]));
        chk({tag, "_undemanded"}, 32'(seen & ~dem), 32'd0);
        done_i = 5'b00000;
    endtask

    initial begin
        int svc_left;
        bit found;

        // en svc dem dn | pe clr ap ar sv fl
        vt[0]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 5'b00100, 5'b00001, 5'b00100, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 5'b00001, 5'b00000, 5'b00001, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 5'b00001, 5'b00100, 5'b00001, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b1, 1'b1};
        vt[15] = '{1'b1, 1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 1'b0, 1'b0};

        // table-driven vectors from reset
        do_reset();
        for (int i = 0; i < 17; i++) begin
            enable_i = vt[i].en; service_i = vt[i].svc; demand_i = vt[i].dem; done_i = vt[i].dn;
            cycle();
            chk($sformatf("tv%0d_phase_en", i), 32'(phase_en_o), 32'(vt[i].pe));
            chk($sformatf("tv%0d_clear", i), 32'(clear_o), 32'(vt[i].clr));
            chk($sformatf("tv%0d_active", i), 32'(active_phase_o), 32'(vt[i].ap));
            chk($sformatf("tv%0d_all_red", i), 32'(all_red_o), 32'(vt[i].ar));
            chk($sformatf("tv%0d_service", i), 32'(service_o), 32'(vt[i].sv));
            chk($sformatf("tv%0d_flash", i), 32'(flash_o), 32'(vt[i].fl));
        end

        // full rotation with wrap
        do_reset();
        exp_g = '{0, 1, 2, 3, 4, 0};
        run_grants(5'b11111, "rot");

        // sparse demand
        do_reset();
        exp_g = '{1, 4, 1, 4};
        run_grants(5'b10010, "sparse");

        // service pre-empts GREEN(3), beacon timing, resume at phase 0
        do_reset();
        enable_i = 1'b1; demand_i = 5'b11111;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            cycle();
            if (phase_en_o[3]) found = 1'b1;
            else done_i = phase_en_o;
        end
        chk("svc_reach_green3", 32'(found), 32'd1);
        done_i = 5'b00000; service_i = 1'b1;
        cycle();
        chk("svc_entry_phase_en", 32'(phase_en_o), 32'd0);
        chk("svc_entry_clear", 32'(clear_o), 32'd0);
        chk("svc_entry_service", 32'(service_o), 32'd1);
        chk("svc_entry_flash", 32'(flash_o), 32'd1);
        for (int n = 2; n <= 20; n++) begin
            cycle();
            chk($sformatf("svc_flash_n%0d", n), 32'(flash_o), 32'(((n - 1) / 8) % 2 == 0));
        end
        service_i = 1'b0;
        for (int n = 1; n <= C; n++) begin
            cycle();
            chk($sformatf("svc_rel_red%0d", n), 32'(all_red_o), 32'd1);
            chk($sformatf("svc_rel_flash%0d", n), 32'(flash_o), 32'd0);
        end
        cycle();
        chk("svc_resume_phase0", 32'(phase_en_o), 32'b00001);

        // asynchronous reset in the middle of clearance
        do_reset();
        enable_i = 1'b1; demand_i = 5'b11111;
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk_reset_vals("async");
        enable_i = 1'b0;
        @(negedge clk_i);
        reset_n = 1'b1;

        // randomized traffic against the model
        do_reset();
        svc_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            enable_i = ($urandom_range(0, 9) != 0);
            demand_i = 5'($urandom);
            if ($urandom_range(0, 2) == 0) done_i = phase_en_o | 5'($urandom & $urandom);
            else done_i = 5'($urandom & $urandom & $urandom);
            if (svc_left > 0) begin
                svc_left--; service_i = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                svc_left = $urandom_range(0, 30); service_i = 1'b1;
            end else begin
                service_i = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) demand_i = 5'b00000;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
